// File: rtl/sparc_mem_pkg.sv
// Shared types for the SPARC MPU RAM loader.
// Holds the loader state encoding and the RAM access/rw encodings.
package sparc_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_PAD,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } ldr_state_t;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/mem_write_port.sv
// RAM write port: drives ram_mov/ram_rw/ram_addr/ram_data, waits for ram_moc.
// Ports: req/wdata/addr_rst in; ack/timeout out (combinational on the MOC cycle).
module mem_write_port
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              req,
  input  logic              addr_rst,
  input  logic [7:0]        wdata,
  input  logic              ram_moc,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_rw,
  output logic              ram_mov,
  output logic              ack,
  output logic              timeout
);

  localparam int TW = $clog2(MOC_TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(MOC_TIMEOUT - 1);

  logic [TW-1:0] tmo;

  assign ack     = ram_mov & ram_moc;
  assign timeout = ram_mov & ~ram_moc & (tmo == TLIM);

  always_ff @(posedge Clk) begin
    if (Clr) begin
      ram_mov  <= 1'b0;
      ram_rw   <= RW_READ;
      ram_addr <= '0;
      ram_data <= '0;
      tmo      <= '0;
    end else begin
      if (addr_rst) ram_addr <= '0;
      if (ram_mov) begin
        if (ram_moc) begin
          ram_mov  <= 1'b0;
          ram_rw   <= RW_READ;
          // natural wrap: only reaches 0 after MEM_BYTES writes
          ram_addr <= ram_addr + 1'b1;
        end else if (tmo == TLIM) begin
          ram_mov <= 1'b0;
          ram_rw  <= RW_READ;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else if (req) begin
        ram_data <= wdata;
        ram_rw   <= RW_WRITE;
        ram_mov  <= 1'b1;
        tmo      <= '0;
      end
    end
  end

endmodule

// File: rtl/sparc_ram_loader.sv
// Streams a program image into MPU RAM, pads it, then releases the MPU.
// Ports: byte stream in (valid/ready/last), RAM strobe/MOC, mpu_clr/done/error.
module sparc_ram_loader
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int MEM_BYTES      = 512,
  parameter int ALIGN          = 4,
  parameter int MOC_TIMEOUT    = 15,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_rw,
  output logic [1:0]        ram_type,
  output logic              ram_mov,
  input  logic              ram_moc,
  output logic              mpu_clr,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  localparam int RW = (RELEASE_CYCLES > 1) ?
                      $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RW-1:0] RLIM =
    (RELEASE_CYCLES > 0) ? RW'(RELEASE_CYCLES - 1) : '0;
  localparam logic [ADDR_W:0] AMASK = (ADDR_W+1)'(ALIGN - 1);
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(MEM_BYTES);

  ldr_state_t      state;
  logic            last_q;
  logic [RW-1:0]   rel_cnt;
  logic            req;
  logic            addr_rst;
  logic [7:0]      wdata;
  logic            ack;
  logic            timeout;
  logic [ADDR_W:0] cnt_inc;
  logic            aligned;
  logic            full;

  assign ram_type = BYTE;
  assign cnt_inc  = byte_count + 1'b1;
  assign aligned  = (cnt_inc & AMASK) == '0;
  assign full     = cnt_inc == FULL;
  assign addr_rst = (state == S_IDLE) & start;
  // PAD issues its next zero write whenever the port is idle
  assign req      = ((state == S_ACCEPT) & in_valid) |
                    ((state == S_PAD) & ~ram_mov);
  assign wdata    = (state == S_PAD) ? 8'h00 : in_data;

  mem_write_port #(
    .ADDR_W      (ADDR_W),
    .MOC_TIMEOUT (MOC_TIMEOUT)
  ) u_port (
    .Clk      (Clk),
    .Clr      (Clr),
    .req      (req),
    .addr_rst (addr_rst),
    .wdata    (wdata),
    .ram_moc  (ram_moc),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_rw   (ram_rw),
    .ram_mov  (ram_mov),
    .ack      (ack),
    .timeout  (timeout)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      mpu_clr    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
      last_q     <= 1'b0;
      rel_cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ACCEPT;
            in_ready   <= 1'b1;
            byte_count <= '0;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            last_q   <= in_last;
            in_ready <= 1'b0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (ack) begin
            byte_count <= cnt_inc;
            if (last_q && !aligned) begin
              state <= S_PAD;
            end else if (last_q) begin
              state   <= S_RELEASE;
              rel_cnt <= '0;
            end else if (full) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state    <= S_ACCEPT;
              in_ready <= 1'b1;
            end
          end else if (timeout) begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        S_PAD: begin
          if (ack) begin
            byte_count <= cnt_inc;
            if (aligned) begin
              state   <= S_RELEASE;
              rel_cnt <= '0;
            end
          end else if (timeout) begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (rel_cnt >= RLIM) begin
            state   <= S_DONE;
            mpu_clr <= 1'b0;
            done    <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        S_DONE: begin
        end
        S_ERROR: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
